// File: rtl/wish_pkg.sv
// Shared defaults and state encoding for the Wishbone multi-master arbiter.
package wish_pkg;

  localparam int NUM_M_DEF   = 4;
  localparam int AW_DEF      = 26;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wish_arbiter_rr_pick.sv
// Round-robin winner select: scans from last+1 upward with wrap, first requester wins.
module wish_rr_pick #(
  parameter int NUM_M = 4,
  parameter int LW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [LW-1:0]    last_i,
  output logic [NUM_M-1:0] win_o
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = LW'((int'(last_i) + i) % NUM_M);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wish_arbiter.sv
// Wishbone N-master to 1-slave arbiter with round-robin grant and slave-ack timeout.
//
// state | meaning
// IDLE  | no grant; arbitrate among m_cyc_i requests
// BUSY  | granted master drives the slave port; wait counter runs
// ERR   | slave timed out; slave port quiet until master drops cyc
module wish_arbiter
  import wish_pkg::*;
#(
  parameter int NUM_M   = NUM_M_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  output logic [DW-1:0]       m_dat_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  input  logic [DW-1:0]       s_dat_i,
  input  logic                s_ack_i,
  output logic [NUM_M-1:0]    gnt_o
);

  localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [NUM_M-1:0] err_q, err_d;
  logic [LW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_M-1:0] win;
  logic [LW-1:0]    gidx;
  logic             timeout_hit;

  wish_rr_pick #(.NUM_M(NUM_M), .LW(LW)) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .win_o  (win)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q[k]) gidx = LW'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      err_q   <= '0;
      last_q  <= LW'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = '0;
    err_d       = '0;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = win;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // an ack arriving on the terminal count beats the timeout
        timeout_hit = s_stb_o && !s_ack_i && (cnt_q == CW'(TIMEOUT));
        if (!m_cyc_i[gidx]) begin
          last_d  = gidx;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          err_d   = gnt_q;
          state_d = ST_ERR;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (s_stb_o && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ERR: begin
        if (!m_cyc_i[gidx]) begin
          last_d  = gidx;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state_q == ST_BUSY) begin
      s_cyc_o = m_cyc_i[gidx];
      s_stb_o = m_stb_i[gidx];
      s_we_o  = m_we_i[gidx];
      s_adr_o = m_adr_i[gidx*AW +: AW];
      s_dat_o = m_dat_i[gidx*DW +: DW];
    end
    m_ack_o = gnt_q & {NUM_M{s_ack_i & s_stb_o}};
  end

  assign m_err_o = err_q;
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wish_arbiter.sv
// Scoreboard bench for wish_arbiter: directed stimulus queues expected grant/ack/err events.
module tb_wish_arbiter;

  localparam int NUM_M   = 4;
  localparam int AW      = 26;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [NUM_M-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [DW-1:0]       m_dat_o;
  logic [NUM_M-1:0]    m_ack_o, m_err_o, gnt_o;
  logic                s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o, s_dat_i;
  logic                s_ack_i;

  wish_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               kind;   // 0 grant, 1 ack, 2 err
    logic [NUM_M-1:0] val;
    logic [AW-1:0]    adr;
    logic [DW-1:0]    dat;
    logic             we;
  } evt_t;

  evt_t             exp_q[$];
  int               n_vec = 0;
  int               n_miss = 0;
  int unsigned      cyc = 0;
  int               err_cyc = -1;
  logic [NUM_M-1:0] prev_gnt = '0;
  logic [NUM_M-1:0] we_pat = 4'b1010;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] exp_adr(int k);
    return AW'(32'h12340 + k * 32'h111);
  endfunction

  function automatic logic [DW-1:0] exp_dat(int k);
    return DW'(32'hD000_0000 + k);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cmp_evt(evt_t o);
    evt_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h, expected no event", o.kind, o.val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != o.kind || e.val !== o.val || e.adr !== o.adr || e.dat !== o.dat || e.we !== o.we) begin
        n_miss++;
        $display("FAIL event: got kind=%0d val=%0h adr=%0h dat=%0h we=%0b, expected kind=%0d val=%0h adr=%0h dat=%0h we=%0b",
                 o.kind, o.val, o.adr, o.dat, o.we, e.kind, e.val, e.adr, e.dat, e.we);
      end
    end
  endtask

  // monitor: every new grant, ack or err the DUT presents is checked against the queue
  always @(negedge clk) begin
    evt_t o;
    if (gnt_o !== prev_gnt && gnt_o != '0) begin
      o.kind = 0; o.val = gnt_o; o.adr = s_adr_o; o.dat = s_dat_o; o.we = s_we_o;
      cmp_evt(o);
    end
    if (m_ack_o != '0) begin
      o.kind = 1; o.val = m_ack_o; o.adr = '0; o.dat = m_dat_o; o.we = 1'b0;
      cmp_evt(o);
    end
    if (m_err_o != '0) begin
      o.kind = 2; o.val = m_err_o; o.adr = '0; o.dat = '0; o.we = 1'b0;
      err_cyc = int'(cyc);
      cmp_evt(o);
    end
    prev_gnt = gnt_o;
  end

  task automatic push_gnt(int g);
    evt_t e;
    e.kind = 0; e.val = 4'b0001 << g; e.adr = exp_adr(g); e.dat = exp_dat(g); e.we = we_pat[g];
    exp_q.push_back(e);
  endtask

  task automatic push_ack(int g, logic [DW-1:0] rd);
    evt_t e;
    e.kind = 1; e.val = 4'b0001 << g; e.adr = '0; e.dat = rd; e.we = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(int g);
    evt_t e;
    e.kind = 2; e.val = 4'b0001 << g; e.adr = '0; e.dat = '0; e.we = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      wait_clk(1);
      if (gnt_o != '0) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL grant_wait: got gnt_o=0 after 16 cycles, expected a grant");
    end
  endtask

  task automatic serve(int g, logic [DW-1:0] rd);
    bit ok;
    wait_gnt(ok);
    if (ok) begin
      s_ack_i = 1'b1;
      s_dat_i = rd;
      push_ack(g, rd);
      wait_clk(1);
      s_ack_i = 1'b0;
    end
    m_cyc_i[g] = 1'b0;
    m_stb_i[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_ack_err", {m_ack_o, m_err_o}, 0);
    wait_clk(2);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    int unsigned busy_c;

    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = we_pat;
    s_ack_i = 1'b0; s_dat_i = '0;
    for (int k = 0; k < NUM_M; k++) begin
      m_adr_i[k*AW +: AW] = exp_adr(k);
      m_dat_i[k*DW +: DW] = exp_dat(k);
    end
    wait_clk(1);

    // single master, one-cycle arbitration latency
    do_reset();
    push_gnt(0);
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    wait_clk(1);
    chk("gnt_latency", gnt_o, 4'b0001);
    chk("s_adr_follow", s_adr_o, exp_adr(0));
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
    push_ack(0, 32'hCAFE_0001);
    wait_clk(1);
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    wait_clk(2);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    push_gnt(0);
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(order[i], 32'hA000_0000 + i);
      if (i < 4) begin
        push_gnt(order[i+1]);
        wait_clk(1);
        m_cyc_i[order[i]] = 1'b1;
        m_stb_i[order[i]] = 1'b1;
      end
    end
    m_cyc_i = '0; m_stb_i = '0;
    wait_clk(2);

    // wrap-around: last=2, requests 0011 -> master 0
    push_gnt(2);
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    serve(2, 32'hB000_0002);
    wait_clk(2);
    push_gnt(0);
    m_cyc_i = 4'b0011; m_stb_i = 4'b0011;
    serve(0, 32'hB000_0000);
    m_cyc_i = '0; m_stb_i = '0;
    wait_clk(2);

    // timeout: slave never acks master 1
    push_gnt(1);
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    wait_gnt(ok);
    busy_c = cyc;
    push_err(1);
    err_cyc = -1;
    for (int i = 0; i < 300 && err_cyc < 0; i++) wait_clk(1);
    chk("err_latency", 64'(err_cyc - int'(busy_c)), 256);
    chk("err_s_cyc_low", s_cyc_o, 0);
    chk("err_gnt_held", gnt_o, 4'b0010);
    wait_clk(3);
    chk("err_single_pulse", m_err_o, 0);
    chk("err_s_stb_low", s_stb_o, 0);
    m_cyc_i = '0; m_stb_i = '0;
    wait_clk(1);
    chk("err_exit_gnt", gnt_o, 0);
    wait_clk(1);

    // ack on terminal count beats timeout (last=1 -> master 2)
    push_gnt(2);
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    wait_gnt(ok);
    wait_clk(255);
    chk("no_err_before_ack", m_err_o, 0);
    s_ack_i = 1'b1; s_dat_i = 32'h5A5A_0255;
    push_ack(2, 32'h5A5A_0255);
    wait_clk(1);
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    wait_clk(3);
    chk("ack_wins_no_err", m_err_o, 0);
    chk("ack_wins_idle", gnt_o, 0);

    // reset mid-BUSY aborts; master 0 then has priority
    push_gnt(3);
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    wait_gnt(ok);
    wait_clk(2);
    rst_i = 1'b1;
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    s_ack_i = 1'b1;
    #1;
    chk("rst_mid_gnt", gnt_o, 0);
    chk("rst_mid_s_cyc", s_cyc_o, 0);
    chk("rst_mid_ack", m_ack_o, 0);
    wait_clk(2);
    s_ack_i = 1'b0;
    push_gnt(0);
    rst_i = 1'b0;
    serve(0, 32'hC0DE_0000);
    m_cyc_i = '0; m_stb_i = '0;
    wait_clk(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
